// File: rtl/adc_stream_capture.sv
// adc_stream_capture: serial-ADC front end for the oscilloscope.
// Generates adc_clk / adc_conv from osc_clk and deserialises each frame.
// Extracts a fixed data field from every frame and gates the samples
// through an armable trigger with a fixed capture length.
module adc_stream_capture #(
  parameter int CLK_DIV_LOG2 = 7,
  parameter int FRAME_BITS   = 16,
  parameter int LEAD_PAD     = 2,
  parameter int DATA_BITS    = 8,
  parameter int CAPTURE_LEN  = 25000
) (
  input  logic                 osc_clk,
  input  logic                 reset,
  input  logic                 adc_data,
  output logic                 adc_clk,
  output logic                 adc_conv,
  input  logic                 arm,
  input  logic [1:0]           trig_mode,
  input  logic [DATA_BITS-1:0] threshold,
  input  logic                 sample_ready,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IDX_W     = $clog2(FRAME_BITS + 1);
  localparam int CNT_W     = $clog2(CAPTURE_LEN + 1);
  localparam int FIELD_LSB = FRAME_BITS - LEAD_PAD - DATA_BITS;

  localparam logic [CLK_DIV_LOG2-1:0] DIV_MAX    = '1;
  // Last cycle with adc_clk low: the next edge raises adc_clk and samples adc_data.
  localparam logic [CLK_DIV_LOG2-1:0] DIV_STROBE = DIV_MAX >> 1;
  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]        CAP_LEN    = CNT_W'(CAPTURE_LEN);

  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_CONT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Serial interface timing
  logic [CLK_DIV_LOG2-1:0] r_div;
  logic [IDX_W-1:0]        r_idx;        // adc_clk period within the frame, 0 = conversion
  logic                    r_conv;
  logic                    r_frame_done; // frame-complete event F
  logic [DATA_BITS-1:0]    r_field;      // extracted data field of the current frame

  logic                    w_wrap;
  logic                    w_strobe;
  logic [DATA_BITS-1:0]    w_field_hit;
  logic [DATA_BITS-1:0]    w_cur;

  // Trigger / capture
  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [DATA_BITS-1:0]    r_prev;
  logic                    r_prev_ok;
  logic [1:0]              r_mode;
  logic [DATA_BITS-1:0]    r_thresh;
  logic                    w_trig;
  logic                    w_emit;

  // Registered outputs
  logic                    r_valid;
  logic [DATA_BITS-1:0]    r_data;
  logic                    r_overrun;
  logic                    r_busy;
  logic                    r_done;

  assign w_wrap   = (r_div == DIV_MAX);
  assign w_strobe = (r_div == DIV_STROBE);
  assign w_cur    = r_field;

  // Free-running divider, frame period counter and conversion strobe (changes only on wrap).
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_conv <= 1'b1;
    end else begin
      r_div <= r_div + CLK_DIV_LOG2'(1);
      if (w_wrap) begin
        if (r_idx == LAST_IDX) begin
          r_idx  <= '0;
          r_conv <= 1'b1;
        end else begin
          r_idx  <= r_idx + IDX_W'(1);
          r_conv <= 1'b0;
        end
      end
    end
  end

  // Each field bit has exactly one period in which its frame bit arrives (MSB first).
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_field_tap
      assign w_field_hit[gi] = w_strobe && (r_idx == IDX_W'(FRAME_BITS - FIELD_LSB - gi));
    end
  endgenerate

  // Capture field bits on the adc_clk rising edge; flag F the cycle after the last bit.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      r_field      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_strobe && (r_idx == LAST_IDX);
      for (int i = 0; i < DATA_BITS; i++) begin
        if (w_field_hit[i]) begin
          r_field[i] <= adc_data;
        end
      end
    end
  end

  // Capture state register.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Trigger evaluation, emit decision and next state; arm overrides a coincident F.
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_trig       = 1'b1;
    w_cnt_inc    = r_cnt + CNT_W'(1);

    case (r_mode)
      MODE_RISE: w_trig = r_prev_ok && (r_prev < r_thresh) && (w_cur >= r_thresh);
      MODE_FALL: w_trig = r_prev_ok && (r_prev >= r_thresh) && (w_cur < r_thresh);
      default:   w_trig = 1'b1;
    endcase

    if (arm) begin
      w_state_next = S_WAIT_TRIG;
    end else if (r_frame_done) begin
      case (r_state)
        S_WAIT_TRIG: begin
          if (w_trig) begin
            w_emit       = 1'b1;
            w_state_next = S_CAPTURE;
          end
        end
        S_CAPTURE: w_emit = 1'b1;
        default: ;
      endcase
      // Continuous mode keeps capturing and lets the count wrap.
      if (w_emit && (r_mode != MODE_CONT) && (w_cnt_inc == CAP_LEN)) begin
        w_state_next = S_DONE;
      end
    end
  end

  // Capture datapath: counters, trigger settings, history and registered outputs.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
      r_mode    <= 2'b00;
      r_thresh  <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_busy  <= (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
      r_done  <= (r_state == S_DONE);
      if (arm) begin
        r_cnt     <= '0;
        r_overrun <= 1'b0;
        r_prev_ok <= 1'b0;
        r_mode    <= trig_mode;
        r_thresh  <= threshold;
      end else begin
        if (r_frame_done) begin
          r_prev    <= w_cur;
          r_prev_ok <= 1'b1;
        end
        if (w_emit) begin
          // A dropped sample still counts toward the capture length.
          r_cnt <= w_cnt_inc;
          if (sample_ready) begin
            r_valid <= 1'b1;
            r_data  <= w_cur;
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign adc_clk      = r_div[CLK_DIV_LOG2-1];
  assign adc_conv     = r_conv;
  assign sample_valid = r_valid;
  assign sample_data  = r_data;
  assign overrun      = r_overrun;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_adc_stream_capture.sv
// Directed testbench for adc_stream_capture (small divider, capture length 4).
module tb_adc_stream_capture;

  logic       osc_clk = 1'b0;
  logic       reset = 1'b1;
  logic       adc_data = 1'b0;
  logic       adc_clk;
  logic       adc_conv;
  logic       arm = 1'b0;
  logic [1:0] trig_mode = 2'b00;
  logic [7:0] threshold = 8'h00;
  logic       sample_ready = 1'b1;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       busy;
  logic       done;
  logic       overrun;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [15:0] adc_q[$];
  logic [15:0] adc_word = 16'h0000;
  int          adc_k = 0;

  int pv_data[$];
  int pv_cyc[$];

  adc_stream_capture #(
    .CLK_DIV_LOG2(2),
    .FRAME_BITS  (16),
    .LEAD_PAD    (2),
    .DATA_BITS   (8),
    .CAPTURE_LEN (4)
  ) dut (
    .osc_clk     (osc_clk),
    .reset       (reset),
    .adc_data    (adc_data),
    .adc_clk     (adc_clk),
    .adc_conv    (adc_conv),
    .arm         (arm),
    .trig_mode   (trig_mode),
    .threshold   (threshold),
    .sample_ready(sample_ready),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 osc_clk = ~osc_clk;

  always @(posedge osc_clk) cyc <= cyc + 1;

  // ADC model: new bit on each adc_clk falling edge; a new word is taken at each conversion period.
  always @(negedge adc_clk) begin
    #1;
    if (adc_conv) begin
      adc_k = 0;
      if (adc_q.size() > 0) adc_word = adc_q.pop_front();
      adc_data = 1'b0;
    end else begin
      adc_k = adc_k + 1;
      if (adc_k <= 16) adc_data = adc_word[16 - adc_k];
    end
  end

  // Record every sample_valid pulse with its cycle number.
  always @(negedge osc_clk) begin
    if (sample_valid === 1'b1) begin
      pv_data.push_back(int'(sample_data));
      pv_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Frame word with non-zero padding so extraction errors show up.
  function automatic logic [15:0] fr(input logic [7:0] v);
    return {2'b10, v, 6'b100101};
  endfunction

  function automatic int pd(input int i);
    return (i < pv_data.size()) ? pv_data[i] : -1;
  endfunction

  function automatic int pc(input int i);
    return (i < pv_cyc.size()) ? pv_cyc[i] : -1;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return adc_conv;
      1:       return adc_clk;
      2:       return done;
      default: return busy;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input string tag, input int sel, input logic lvl,
                            input int maxc, output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge osc_clk);
      if (sig(sel) === lvl) begin
        found = 1'b1;
        at = cyc;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge osc_clk);
  endtask

  // Arm at the start of a conversion period; returns that cycle number.
  task automatic arm_at_frame(input logic [1:0] m, input logic [7:0] th, output int a);
    int t;
    wait_level("arm_sync_conv_low", 0, 1'b0, 200, t);
    wait_level("arm_sync_conv_high", 0, 1'b1, 200, a);
    trig_mode = m;
    threshold = th;
    arm = 1'b1;
    @(negedge osc_clk);
    arm = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_adc_clk"}, adc_clk, 0);
    check({p, "_adc_conv"}, adc_conv, 1);
    check({p, "_sample_valid"}, sample_valid, 0);
    check({p, "_sample_data"}, sample_data, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int a, t, t0, t1, t2, t3, u1, u2, rc;

    // 1: reset values, divider and conversion timing, quiet while idle
    repeat (5) @(negedge osc_clk);
    check_reset_vals("t1_reset");
    rc = cyc;
    reset = 1'b0;
    $display("step reset released at cycle %0d", rc);
    wait_level("t1_conv_fall", 0, 1'b0, 100, t0);
    check("t1_first_conv_len", t0 - rc, 4);
    wait_level("t1_conv_rise", 0, 1'b1, 100, t1);
    wait_level("t1_conv_fall2", 0, 1'b0, 100, t2);
    wait_level("t1_conv_rise2", 0, 1'b1, 100, t3);
    check("t1_conv_high_len", t2 - t1, 4);
    check("t1_frame_period", t3 - t1, 68);
    wait_level("t1_clk_rise", 1, 1'b1, 20, u1);
    wait_level("t1_clk_fall", 1, 1'b0, 20, t);
    wait_level("t1_clk_rise2", 1, 1'b1, 20, u2);
    check("t1_adc_clk_period", u2 - u1, 4);
    check("t1_idle_no_valid", pv_data.size(), 0);

    // 2: immediate mode, word 16'h2AC0 -> 4 samples of 8'hAB
    adc_q.push_back(16'h2AC0);
    pv_data.delete(); pv_cyc.delete();
    arm_at_frame(2'b00, 8'h00, a);
    $display("step t2 armed mode 00 at cycle %0d", a);
    check("t2_busy_lag", busy, 0);
    @(negedge osc_clk);
    check("t2_busy_set", busy, 1);
    wait_level("t2_done_wait", 2, 1'b1, 600, t);
    check("t2_count", pv_data.size(), 4);
    check("t2_latency", pc(0) - a, 67);
    check("t2_spacing01", pc(1) - pc(0), 68);
    check("t2_spacing23", pc(3) - pc(2), 68);
    for (int i = 0; i < 4; i++) check($sformatf("t2_data%0d", i), pd(i), 8'hAB);
    check("t2_done_lag", t - pc(3), 1);
    check("t2_busy_clear", busy, 0);
    repeat (100) @(negedge osc_clk);
    check("t2_no_extra", pv_data.size(), 4);
    check("t2_done_hold", done, 1);

    // 3: rising edge through 0x80
    adc_q.push_back(fr(8'h10)); adc_q.push_back(fr(8'h70)); adc_q.push_back(fr(8'h90));
    adc_q.push_back(fr(8'hA0)); adc_q.push_back(fr(8'hB0)); adc_q.push_back(fr(8'hC0));
    pv_data.delete(); pv_cyc.delete();
    arm_at_frame(2'b01, 8'h80, a);
    $display("step t3 armed mode 01 at cycle %0d", a);
    wait_level("t3_done_wait", 2, 1'b1, 700, t);
    check("t3_count", pv_data.size(), 4);
    check("t3_fire_time", pc(0) - a, 67 + 136);
    check("t3_data0", pd(0), 8'h90);
    check("t3_data1", pd(1), 8'hA0);
    check("t3_data2", pd(2), 8'hB0);
    check("t3_data3", pd(3), 8'hC0);

    // 4: falling edge; first frame after arm cannot fire
    adc_q.push_back(fr(8'h40)); adc_q.push_back(fr(8'h90)); adc_q.push_back(fr(8'h40));
    adc_q.push_back(fr(8'h30)); adc_q.push_back(fr(8'h20)); adc_q.push_back(fr(8'h10));
    pv_data.delete(); pv_cyc.delete();
    arm_at_frame(2'b10, 8'h80, a);
    $display("step t4 armed mode 10 at cycle %0d", a);
    wait_level("t4_done_wait", 2, 1'b1, 700, t);
    check("t4_count", pv_data.size(), 4);
    check("t4_fire_time", pc(0) - a, 67 + 136);
    check("t4_data0", pd(0), 8'h40);
    check("t4_data1", pd(1), 8'h30);
    check("t4_data2", pd(2), 8'h20);
    check("t4_data3", pd(3), 8'h10);

    // 5: sample 2 dropped by backpressure
    adc_q.push_back(fr(8'h11)); adc_q.push_back(fr(8'h22));
    adc_q.push_back(fr(8'h33)); adc_q.push_back(fr(8'h44));
    pv_data.delete(); pv_cyc.delete();
    arm_at_frame(2'b00, 8'h00, a);
    $display("step t5 armed mode 00 at cycle %0d", a);
    wait_until(a + 100);
    sample_ready = 1'b0;
    wait_until(a + 170);
    sample_ready = 1'b1;
    wait_level("t5_done_wait", 2, 1'b1, 600, t);
    check("t5_count", pv_data.size(), 3);
    check("t5_data0", pd(0), 8'h11);
    check("t5_data1", pd(1), 8'h33);
    check("t5_data2", pd(2), 8'h44);
    check("t5_last_time", pc(2) - a, 67 + 204);
    check("t5_done_lag", t - pc(2), 1);
    check("t5_overrun", overrun, 1);

    // 6a: re-arm clears overrun, then re-arm again mid-capture
    adc_q.push_back(fr(8'h55)); adc_q.push_back(fr(8'h66)); adc_q.push_back(fr(8'h77));
    adc_q.push_back(fr(8'h88)); adc_q.push_back(fr(8'h99));
    pv_data.delete(); pv_cyc.delete();
    arm_at_frame(2'b00, 8'h00, a);
    $display("step t6 armed mode 00 at cycle %0d", a);
    check("t6_overrun_cleared", overrun, 0);
    @(negedge osc_clk);
    check("t6_busy_rearm", busy, 1);
    check("t6_done_cleared", done, 0);
    wait_until(a + 150);
    check("t6_two_before_rearm", pv_data.size(), 2);
    arm = 1'b1;
    @(negedge osc_clk);
    arm = 1'b0;
    $display("step t6 re-armed mid-capture at cycle %0d", a + 150);
    wait_level("t6_done_wait", 2, 1'b1, 600, t);
    check("t6_count", pv_data.size(), 6);
    check("t6_data2", pd(2), 8'h77);
    check("t6_data3", pd(3), 8'h88);
    check("t6_data5", pd(5), 8'h99);
    check("t6_restart_time", pc(2) - a, 203);
    check("t6_done_time", t - a, 408);

    // 6b: continuous mode runs past CAPTURE_LEN, then reset mid-frame
    adc_q.push_back(fr(8'hC1)); adc_q.push_back(fr(8'hC2)); adc_q.push_back(fr(8'hC3));
    adc_q.push_back(fr(8'hC4)); adc_q.push_back(fr(8'hC5)); adc_q.push_back(fr(8'hC6));
    pv_data.delete(); pv_cyc.delete();
    arm_at_frame(2'b11, 8'h00, a);
    $display("step t6b armed mode 11 at cycle %0d", a);
    wait_until(a + 67 + 136 - 30);
    sample_ready = 1'b0;
    wait_until(a + 67 + 136 + 30);
    sample_ready = 1'b1;
    wait_until(a + 67 + 340 + 10);
    check("t6b_count", pv_data.size(), 5);
    check("t6b_data1", pd(1), 8'hC2);
    check("t6b_data2", pd(2), 8'hC4);
    check("t6b_data4", pd(4), 8'hC6);
    check("t6b_overrun", overrun, 1);
    check("t6b_busy", busy, 1);
    check("t6b_done", done, 0);
    wait_level("t6b_clk_high", 1, 1'b1, 20, t);
    reset = 1'b1;
    @(negedge osc_clk);
    check_reset_vals("t6b_reset");
    rc = cyc;
    reset = 1'b0;
    $display("step t6b mid-frame reset released at cycle %0d", rc);
    pv_data.delete(); pv_cyc.delete();
    wait_level("t6b_conv_fall", 0, 1'b0, 100, t);
    check("t6b_conv_len", t - rc, 4);
    repeat (150) @(negedge osc_clk);
    check("t6b_idle_no_valid", pv_data.size(), 0);
    check("t6b_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
